mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the data memory port.
REQ-002 Parameter DATA_W, default 32, word width of the data memory port.
REQ-003 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-004 Ports SHALL be as follows:
  clk         in   1         rising-edge clock
  rst_n       in   1         asynchronous active-low reset
  start       in   1         request; sampled on rising edge in IDLE only
  mode        in   1         0 = copy src->dst, 1 = fill dst with fill_data
  src_addr    in   ADDR_W    copy source start word address
  dst_addr    in   ADDR_W    destination start word address
  len         in   ADDR_W+1  word count, 0..2^ADDR_W
  fill_data   in   DATA_W    fill pattern
  busy        out  1         operation in progress
  done        out  1         one-cycle completion pulse
  words_done  out  ADDR_W+1  words written in current/last operation
  mem_we      out  1         memory write enable (write on rising edge)
  mem_addr    out  ADDR_W    memory address
  mem_wdata   out  DATA_W    memory write data
  mem_rdata   in   DATA_W    memory read data, combinational from mem_addr

Function
REQ-005 FSM states SHALL be IDLE, RD, WR, FILL, DONE; outputs are decoded from registered state/pointers only, with no combinational path from start/mode/addr inputs.
REQ-006 In IDLE, a rising edge with start=1 SHALL latch mode, src_addr, dst_addr, fill_data, and the effective length (len clamped to 2^ADDR_W), clear words_done, and move to RD (copy), FILL (fill), or DONE (effective length 0).
REQ-007 RD: mem_addr=src_ptr, mem_we=0; on the next edge mem_rdata SHALL be captured into an internal data register and the FSM SHALL go to WR.
REQ-008 WR: mem_addr=dst_ptr, mem_we=1, mem_wdata=captured data; on the edge, src_ptr, dst_ptr, and words_done SHALL increment, then go to DONE if words_done reaches the length, else RD.
REQ-009 FILL: mem_addr=dst_ptr, mem_we=1, mem_wdata=latched fill_data; per edge, dst_ptr and words_done SHALL increment, then go to DONE at the length, else stay in FILL.
REQ-010 Copy SHALL take 2 cycles per word; fill SHALL take 1 cycle per word; for a start edge E0 and length N>0, the last write edge SHALL be E(2N) for copy and E(N) for fill, with done high during the following cycle.
REQ-011 DONE SHALL last exactly one cycle with done=1, busy=0, mem_we=0, then return to IDLE; start in DONE SHALL be ignored.
REQ-012 busy SHALL be 1 exactly in RD, WR, and FILL; start while busy SHALL be ignored, and latched operands SHALL not change mid-operation.
REQ-013 Pointers SHALL wrap modulo 2^ADDR_W (1023 -> 0) without error.
REQ-014 Overlapping regions SHALL be copied strictly forward, one word at a time; the result is the defined forward-copy outcome.
REQ-015 In IDLE and DONE, mem_we SHALL be 0, mem_addr SHALL be 0, and mem_wdata SHALL be 0.
REQ-016 words_done SHALL hold its final value after DONE until the next accepted start.

Reset
REQ-017 While rst_n=0, immediately and independent of clk: state=IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, words_done=0, and internal pointers/data register = 0.
REQ-018 Reset asserted mid-operation SHALL abort with no further memory writes; words already written stay in memory, and after release the block SHALL accept a new start.

Verification
REQ-019 Preload mem[10..13]=0xA0..0xA3, then copy src=10, dst=100, len=4 -> mem[100..103]=0xA0..0xA3, done at the cycle after edge E8, words_done=4, busy high for 8 cycles.
REQ-020 Fill dst=500, len=3, fill_data=0xBBBBBBBB -> mem[500..502]=0xBBBBBBBB, mem[503] unchanged, done after E3.
REQ-021 Start with len=0 -> no mem_we pulse, done in the cycle after the start edge, busy never high.
REQ-022 Fill dst=1022, len=4, pattern 0x5 -> mem[1022], mem[1023], mem[0], mem[1] = 0x5 (wrap).
REQ-023 Start pulsed again with new operands while a copy is busy -> ignored, with original destination/data only; then copy src=20, dst=21, len=3 over mem[20..22]=1,2,3 -> mem[21..23]=1,1,1 (forward overlap).
REQ-024 Assert rst_n=0 after the 2nd write of a 6-word fill -> mem_we drops immediately, only 2 words are modified, and a subsequent start completes normally.

Source files
------------

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - word copy / fill engine driving a single-port data memory
// Outputs are flops loaded from the next-state decode, so no input reaches a port combinationally.
module mem_copy_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_FILL, S_DONE} state_t;

  localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_L   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
  logic [DATA_W-1:0]   fill_q, fill_d, data_q, data_d;
  logic [ADDR_W:0]     len_q, len_d, cnt_q, cnt_d;
  logic                busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W:0]     eff_len, cnt_inc;

  // Any len with the top bit set is at least 2^ADDR_W, so it saturates there.
  assign eff_len = len[ADDR_W] ? MAX_LEN : len;
  assign cnt_inc = cnt_q + ONE_L;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    fill_d  = fill_q;
    data_d  = data_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          fill_d = fill_data;
          len_d  = eff_len;
          cnt_d  = '0;
          if (eff_len == '0) state_d = S_DONE;
          else if (mode)     state_d = S_FILL;
          else               state_d = S_RD;
        end
      end
      S_RD: begin
        data_d  = mem_rdata;
        state_d = S_WR;
      end
      S_WR: begin
        src_d   = src_q + ONE_A;
        dst_d   = dst_q + ONE_A;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? S_DONE : S_RD;
      end
      S_FILL: begin
        dst_d   = dst_q + ONE_A;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? S_DONE : S_FILL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_RD) || (state_d == S_WR) || (state_d == S_FILL);
    done_d  = (state_d == S_DONE);
    we_d    = (state_d == S_WR) || (state_d == S_FILL);
    addr_d  = '0;
    wdata_d = '0;
    case (state_d)
      S_RD:    addr_d = src_d;
      S_WR:    begin addr_d = dst_d; wdata_d = data_d; end
      S_FILL:  begin addr_d = dst_d; wdata_d = fill_d; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign words_done = cnt_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - scoreboard bench for mem_copy_engine
// Expected writes/completions come from a word-level model of copy/fill over a reference array.
module tb_mem_copy_engine;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, mode;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   len;
  logic [DW-1:0] fill_data;
  logic          busy, done, mem_we;
  logic [AW:0]   words_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
    .busy(busy), .done(done), .words_done(words_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { int lat; int words; int busy_cycles; } dn_t;

  wr_t wr_q[$];
  dn_t dn_q[$];
  wr_t mon_w;
  dn_t mon_d;

  int vectors = 0;
  int miscompares = 0;
  int neg_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int start_neg = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      neg_cnt++;
      if (busy) busy_cnt++;
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write_addr", {54'd0, mem_addr}, 64'hFFFF);
        end else begin
          mon_w = wr_q.pop_front();
          chk("wr_addr", {54'd0, mem_addr}, {54'd0, mon_w.addr});
          chk("wr_data", {32'd0, mem_wdata}, {32'd0, mon_w.data});
        end
      end else if (!busy) begin
        chk("idle_addr", {54'd0, mem_addr}, 64'd0);
        chk("idle_wdata", {32'd0, mem_wdata}, 64'd0);
      end
      if (done) begin
        if (dn_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_d = dn_q.pop_front();
          chk("done_latency", 64'(neg_cnt - start_neg), 64'(mon_d.lat));
          chk("words_done", {53'd0, words_done}, 64'(mon_d.words));
          chk("busy_cycles", 64'(busy_cnt), 64'(mon_d.busy_cycles));
          chk("busy_in_done", {63'd0, busy}, 64'd0);
        end
        busy_cnt = 0;
        done_cnt++;
      end
    end
  end

  task automatic start_op(input bit m, input int src, input int dst, input int l, input logic [DW-1:0] fd);
    @(negedge clk);
    mode = m; src_addr = AW'(src); dst_addr = AW'(dst); len = (AW+1)'(l); fill_data = fd;
    start = 1'b1;
    @(posedge clk);
    #1;
    start_neg = neg_cnt;
    start = 1'b0;
    mode = 1'($urandom); src_addr = AW'($urandom); dst_addr = AW'($urandom);
    len = (AW+1)'($urandom); fill_data = $urandom;
  endtask

  task automatic wait_done(input int n0, input int exp_words);
    for (int k = 0; k < 5000 && done_cnt == n0; k++) @(negedge clk);
    if (done_cnt == n0) begin
      chk("done_timeout", 64'd0, 64'd1);
      wr_q.delete();
      dn_q.delete();
    end
    @(negedge clk);
    chk("writes_pending", 64'(wr_q.size()), 64'd0);
    chk("words_done_hold", {53'd0, words_done}, 64'(exp_words));
  endtask

  task automatic run_op(input bit m, input int src, input int dst, input int l,
                        input logic [DW-1:0] fd, input bit poke);
    int eff, n0, a;
    logic [DW-1:0] v;
    eff = (l > DEPTH) ? DEPTH : l;
    for (int i = 0; i < eff; i++) begin
      a = (dst + i) % DEPTH;
      v = m ? fd : ref_mem[(src + i) % DEPTH];
      ref_mem[a] = v;
      wr_q.push_back('{AW'(a), v});
    end
    dn_q.push_back('{(eff == 0) ? 1 : (m ? eff + 1 : 2 * eff + 1), eff, m ? eff : 2 * eff});
    n0 = done_cnt;
    start_op(m, src, dst, l, fd);
    if (poke) begin
      @(negedge clk);
      @(negedge clk);
      mode = 1'($urandom); src_addr = AW'($urandom); dst_addr = AW'($urandom);
      len = (AW+1)'($urandom_range(1, 8)); fill_data = $urandom;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(n0, eff);
  endtask

  task automatic preload(input int a, input logic [DW-1:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    len = '0; fill_data = '0;
    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
    #3;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_we", {63'd0, mem_we}, 64'd0);
    chk("rst_addr", {54'd0, mem_addr}, 64'd0);
    chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("rst_words", {53'd0, words_done}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) preload(10 + i, 32'hA0 + i);
    run_op(1'b0, 10, 100, 4, 32'h0, 1'b0);
    run_op(1'b1, 0, 500, 3, 32'hBBBBBBBB, 1'b0);
    run_op(1'b0, 7, 9, 0, 32'h0, 1'b0);
    run_op(1'b1, 0, 1022, 4, 32'h5, 1'b0);
    for (int i = 0; i < 3; i++) preload(20 + i, 32'(i + 1));
    run_op(1'b0, 20, 21, 3, 32'h0, 1'b1);
    run_op(1'b0, 1021, 1022, 4, 32'h0, 1'b0);

    begin : reset_abort
      int n0;
      for (int i = 0; i < 2; i++) begin
        ref_mem[300 + i] = 32'hC0DE0000;
        wr_q.push_back('{AW'(300 + i), 32'hC0DE0000});
      end
      n0 = done_cnt;
      start_op(1'b1, 0, 300, 6, 32'hC0DE0000);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_we", {63'd0, mem_we}, 64'd0);
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_addr", {54'd0, mem_addr}, 64'd0);
      chk("abort_words", {53'd0, words_done}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_no_done", 64'(done_cnt - n0), 64'd0);
      chk("abort_pending", 64'(wr_q.size()), 64'd0);
    end

    run_op(1'b1, 0, 302, 2, 32'h12345678, 1'b0);

    for (int t = 0; t < 24; t++) begin
      bit m;
      int l;
      m = 1'($urandom);
      l = $urandom_range(0, 9);
      run_op(m, $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), l,
             $urandom, (!m && l >= 3) ? 1'($urandom) : 1'b0);
    end

    run_op(1'b1, 0, 700, 1500, 32'hFACEFACE, 1'b0);
    run_op(1'b0, 1000, 5, 12, 32'h0, 1'b1);

    for (int i = 0; i < DEPTH; i++) chk($sformatf("mem[%0d]", i), {32'd0, mem[i]}, {32'd0, ref_mem[i]});
    chk("dn_pending", 64'(dn_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
